// File: rtl/cordic_pkg.sv
// Shared defaults and the {valid, tag} record that travels alongside the CORDIC pipeline.
package cordic_pkg;
    localparam int CORDIC_DATA_WIDTH = 32;
    localparam int CORDIC_LATENCY    = 41;
    localparam int TAG_MAX_W         = 3;  // wide enough for up to 8 requesters

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } tag_rec_t;
endpackage

// File: rtl/cordic_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first eligible requester at or after ptr.
module cordic_rr_arb
    import cordic_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = tag_width(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [TW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [TW-1:0] grant_idx
);
    logic [TW-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest eligible one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + TW'(k);
            if (eligible[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/cordic_scheduler.sv
// Shares one fixed-latency CORDIC pipeline among N_REQ requesters with credit-based result FIFOs.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = CORDIC_DATA_WIDTH,
    parameter int N_REQ      = 4,
    parameter int LATENCY    = CORDIC_LATENCY,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [N_REQ*DATA_WIDTH-1:0] rsp_data,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]       cu_din,
    input  logic [DATA_WIDTH-1:0]       cu_dout,
    output logic                        busy
);
    localparam int TW = tag_width(N_REQ);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(RSP_DEPTH);

    logic [N_REQ-1:0]      eligible;
    logic [N_REQ-1:0]      grant;
    logic [N_REQ-1:0]      wb_hit;
    logic [N_REQ-1:0]      active;
    logic [TW-1:0]         grant_idx;
    logic [TW-1:0]         rr_ptr;
    logic                  accept;
    logic                  issue_valid;
    logic [TW-1:0]         issue_tag;
    logic [DATA_WIDTH-1:0] issue_data;
    logic [DATA_WIDTH-1:0] req_words [N_REQ];
    tag_rec_t              tag_pipe [LATENCY];
    tag_rec_t              wb_rec;

    cordic_rr_arb #(.N(N_REQ), .TW(TW)) u_arb (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign cu_din    = issue_valid ? issue_data : '0;
    assign wb_rec    = tag_pipe[LATENCY-1];
    assign busy      = |active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            issue_valid <= 1'b0;
            issue_tag   <= '0;
            for (int k = 0; k < LATENCY; k++) tag_pipe[k] <= '0;
        end else begin
            if (accept) rr_ptr <= grant_idx + TW'(1);
            issue_valid     <= accept;
            issue_tag       <= grant_idx;
            tag_pipe[0].valid <= issue_valid;
            tag_pipe[0].tag   <= TAG_MAX_W'(issue_tag);
            for (int k = 1; k < LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) issue_data <= req_words[grant_idx];
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
            logic [AW-1:0]         wr_ptr;
            logic [AW-1:0]         rd_ptr;
            logic [CW-1:0]         count;
            logic [CW-1:0]         inflight;
            logic [CW:0]           used;
            logic                  pop;

            assign req_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wb_hit[gi]    = wb_rec.valid && (wb_rec.tag == TAG_MAX_W'(gi));
            assign pop           = (count != '0) && rsp_ready[gi];
            // Results already queued plus those still in the pipe can never exceed the FIFO.
            assign used          = {1'b0, count} + {1'b0, inflight};
            assign eligible[gi]  = rst_n && req_valid[gi] && (used < DEPTH_LIM);
            assign rsp_valid[gi] = (count != '0);
            assign rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = fifo_mem[rd_ptr];
            assign active[gi]    = (count != '0) || (inflight != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    count    <= '0;
                    inflight <= '0;
                end else begin
                    if (wb_hit[gi]) wr_ptr <= wr_ptr + AW'(1);
                    if (pop) rd_ptr <= rd_ptr + AW'(1);
                    count    <= count + CW'(wb_hit[gi]) - CW'(pop);
                    inflight <= inflight + CW'(grant[gi]) - CW'(wb_hit[gi]);
                end
            end

            always_ff @(posedge clk) begin
                if (wb_hit[gi]) fifo_mem[wr_ptr] <= cu_dout;
            end
        end
    endgenerate
endmodule

// File: tb/tb_cordic_scheduler.sv
// Randomized bench for cordic_scheduler against a queue-based model of credits, arbitration and results.
module tb_cordic_scheduler;
    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int LAT   = 41;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] ready_cyc;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*DW-1:0]  req_data, rsp_data;
    logic [DW-1:0]     cu_din, cu_dout;
    logic              busy;
    logic [DW-1:0]     pipe [LAT];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    res_t exp_q [NR][$];
    int outstanding [NR];
    int acc_cnt [NR];
    int dut_acc [NR];
    int dut_pops [NR];
    int last_grant;
    logic [DW-1:0]    exp_cu_din;
    logic [NR-1:0]    obs_ready, obs_rv;
    logic [NR*DW-1:0] obs_rsp;
    logic             obs_busy;
    int               obs_cyc;

    cordic_scheduler #(.DATA_WIDTH(DW), .N_REQ(NR), .LATENCY(LAT), .RSP_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .cu_din    (cu_din),
        .cu_dout   (cu_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the CORDIC core: an arbitrary function delayed by LAT cycles.
    function automatic logic [31:0] cordic_ref(input logic [31:0] x);
        return (x * 32'd3) ^ 32'hC0DE_1234;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= cordic_ref(cu_din);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        cyc <= cyc + 1;
    end
    assign cu_dout = pipe[LAT-1];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int total_out();
        int s = 0;
        for (int i = 0; i < NR; i++) s += outstanding[i];
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            exp_q[i].delete();
            outstanding[i] = 0;
        end
        last_grant = NR - 1;
        exp_cu_din = '0;
    endtask

    // Called just after a rising edge with inputs already driven; checks at the falling edge.
    task automatic step();
        logic [NR-1:0] exp_ready, exp_rv;
        int g;
        @(negedge clk);
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_rsp   = rsp_data;
        obs_busy  = busy;
        obs_cyc   = cyc;
        exp_ready = '0;
        g = -1;
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last_grant + k) % NR;
            if (g < 0 && req_valid[i] && outstanding[i] < DEPTH) g = i;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check_val("req_ready", req_ready, exp_ready);
        check_val("cu_din", cu_din, exp_cu_din);
        check_val("busy", busy, total_out() > 0);
        for (int i = 0; i < NR; i++)
            exp_rv[i] = (exp_q[i].size() > 0) && (int'(exp_q[i][0].ready_cyc) <= cyc);
        check_val("rsp_valid", rsp_valid, exp_rv);
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) dut_acc[i]++;
            if (rsp_valid[i] && rsp_ready[i]) dut_pops[i]++;
            if (exp_rv[i]) begin
                check_val("rsp_data", rsp_data[i*DW +: DW], exp_q[i][0].value);
                if (rsp_ready[i]) begin
                    $display("rsp req=%0d data=%h cyc=%0d", i, rsp_data[i*DW +: DW], cyc);
                    void'(exp_q[i].pop_front());
                    outstanding[i]--;
                end
            end
        end
        exp_cu_din = '0;
        if (g >= 0) begin
            res_t r;
            r.value     = cordic_ref(req_data[g*DW +: DW]);
            r.ready_cyc = 32'(cyc + LAT + 2);
            exp_q[g].push_back(r);
            outstanding[g]++;
            acc_cnt[g]++;
            last_grant = g;
            exp_cu_din = req_data[g*DW +: DW];
            $display("acc req=%0d data=%h cyc=%0d", g, req_data[g*DW +: DW], cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, req_ready, '0);
        check_val({tag, "_rsp_valid"}, rsp_valid, '0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_cu_din"}, cu_din, '0);
    endtask

    task automatic apply_reset();
        req_valid = '1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int n = 0; n < 200 && (total_out() > 0 || busy); n++) step();
        check_val("drain_outstanding", total_out(), 0);
    endtask

    initial begin
        int t0, first, gap, base, sent, stale;
        logic [31:0] cur;
        logic [31:0] sent_q[$];
        logic [31:0] got_q[$];

        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;
        for (int i = 0; i < NR; i++) begin
            acc_cnt[i] = 0; dut_acc[i] = 0; dut_pops[i] = 0;
        end
        #1;
        apply_reset();

        // Single operation from requester 2.
        t0 = cyc;
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 32'h0001_0000;
        step();
        req_valid = '0;
        first = -1;
        gap = 0;
        for (int n = 0; n < 80 && first < 0; n++) begin
            step();
            if (!obs_busy) gap++;
            if (obs_rv[2]) first = obs_cyc - t0;
        end
        check_val("single_latency", first, LAT + 2);
        check_val("single_data", obs_rsp[2*DW +: DW], cordic_ref(32'h0001_0000));
        rsp_ready[2] = 1'b1;
        step();
        if (!obs_busy) gap++;
        check_val("single_busy_gap", gap, 0);
        rsp_ready = '0;
        step();

        // Fairness with every requester asking and draining.
        req_valid = '1;
        rsp_ready = '1;
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
            step();
        end
        drain();

        // Credit stall on requester 1.
        rsp_ready = '0;
        req_valid = 4'b0010;
        base = dut_acc[1];
        for (int n = 0; n < 60; n++) begin
            req_data[DW +: DW] = $urandom;
            step();
        end
        check_val("credit_accepts", dut_acc[1] - base, DEPTH);
        check_val("credit_ready_low", obs_ready[1], 1'b0);
        rsp_ready[1] = 1'b1;
        step();
        rsp_ready = '0;
        step();
        check_val("credit_regrant", obs_ready[1], 1'b1);
        step();
        check_val("credit_ready_low2", obs_ready[1], 1'b0);
        drain();

        // In-order delivery for requester 3 under random back-pressure.
        base = acc_cnt[3];
        rsp_ready = '0;
        req_valid = '0;
        req_data[3*DW +: DW] = {8'h30, 8'd0, 16'($urandom)};
        for (int n = 0; n < 600 && got_q.size() < 8; n++) begin
            sent = acc_cnt[3] - base;
            cur = req_data[3*DW +: DW];
            req_valid[3] = (sent < 8);
            rsp_ready[3] = 1'($urandom_range(0, 1));
            step();
            if (acc_cnt[3] - base != sent) begin
                sent_q.push_back(cordic_ref(cur));
                req_data[3*DW +: DW] = {8'h30, 8'(sent + 1), 16'($urandom)};
            end
            if (obs_rv[3] && rsp_ready[3]) got_q.push_back(obs_rsp[3*DW +: DW]);
        end
        check_val("order_count", got_q.size(), 8);
        for (int k = 0; k < got_q.size() && k < sent_q.size(); k++)
            check_val("order_data", got_q[k], sent_q[k]);
        drain();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            req_valid = NR'($urandom);
            rsp_ready = NR'($urandom);
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
            step();
        end
        drain();

        // Reset with ten operations in flight.
        base = 0;
        for (int i = 0; i < NR; i++) base += acc_cnt[i];
        req_valid = '1;
        rsp_ready = '0;
        for (int n = 0; n < 40; n++) begin
            sent = -base;
            for (int i = 0; i < NR; i++) sent += acc_cnt[i];
            if (sent >= 10) break;
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
            step();
        end
        check_val("midflight_count", sent, 10);
        apply_reset();
        stale = 0;
        for (int n = 0; n < 50; n++) begin
            rsp_ready = NR'($urandom);
            step();
            if (obs_rv != '0) stale++;
        end
        check_val("midflight_stale", stale, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of operand and result words.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (power of two, 2..8).
REQ-003 SHALL have parameter LATENCY, default 41, clock cycles from a value on cu_din to its result on cu_dout.
REQ-004 SHALL have parameter RSP_DEPTH, default 4, entries in each per-requester result FIFO (power of two).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, N_REQ, per-requester operand valid.
REQ-008 SHALL have port req_data, input, N_REQ*DATA_WIDTH, per-requester operand; slice i belongs to requester i.
REQ-009 SHALL have port req_ready, output, N_REQ, per-requester accept, one-hot or zero.
REQ-010 SHALL have port rsp_valid, output, N_REQ, per-requester result available.
REQ-011 SHALL have port rsp_data, output, N_REQ*DATA_WIDTH, per-requester result (FIFO head).
REQ-012 SHALL have port rsp_ready, input, N_REQ, per-requester result consume.
REQ-013 SHALL have port cu_din, output, DATA_WIDTH, operand to the shared CORDIC pipeline.
REQ-014 SHALL have port cu_dout, input, DATA_WIDTH, result from the shared CORDIC pipeline.
REQ-015 SHALL have port busy, output, 1, high while any operation is in flight or any FIFO is non-empty.

Function
REQ-016 SHALL accept at most one operand per cycle; a transfer occurs on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-017 SHALL compute credit_i = RSP_DEPTH - fifo_count_i - inflight_i; requester i is eligible only when req_valid[i] is high and credit_i > 0.
REQ-018 SHALL grant round-robin among eligible requesters; priority starts at the index after the last granted requester; after reset it starts at requester 0.
REQ-019 SHALL drive req_ready combinationally from eligibility and the priority pointer; req_ready SHALL NOT depend on rsp_ready in the same cycle.
REQ-020 SHALL register an accepted operand into an issue register (data, valid, tag = requester index); cu_din = issue data, or 0 when issue valid is low.
REQ-021 SHALL carry {valid, tag} through a LATENCY-deep shift register aligned with the pipeline, so that its output is paired with cu_dout.
REQ-022 SHALL write cu_dout into FIFO[tag] at the edge where the tag-pipe output is valid; an operand accepted in cycle 0 SHALL produce rsp_valid in cycle LATENCY+2 (43 by default) when its FIFO was empty.
REQ-023 SHALL increment inflight_i on accept and decrement it on write-back; accept and write-back in the same cycle SHALL leave inflight_i unchanged.
REQ-024 SHALL present each FIFO first-word-fall-through: rsp_valid[i] = non-empty, rsp_data slice i = head; pop on rsp_valid[i] && rsp_ready[i].
REQ-025 SHALL free a credit on pop starting the following cycle; a pop and a write in the same cycle on one FIFO SHALL keep its count unchanged.
REQ-026 SHALL never overflow a FIFO (guaranteed by credits) and SHALL ignore rsp_ready while the FIFO is empty.
REQ-027 SHALL return results to each requester in the order that requester's operands were accepted.
REQ-028 SHALL sustain one accept per cycle when requesters drain responses every cycle.

Reset
REQ-029 SHALL on rst_n low clear asynchronously: issue valid, all tag-pipe valid bits, all FIFO pointers and counts, all inflight counters; priority pointer = 0.
REQ-030 SHALL hold req_ready = 0, rsp_valid = 0, busy = 0 and cu_din = 0 during reset; rsp_data is don't-care.
REQ-031 SHALL discard results of operations in flight when reset asserts mid-operation; cu_dout values after deassertion SHALL be ignored until valid tags arrive.

Structure
REQ-032 SHALL place DATA_WIDTH, LATENCY defaults, the tag-width function (clog2 of N_REQ) and the {valid, tag} record type in shared package cordic_pkg.
REQ-033 SHALL implement the round-robin grant in sub-module cordic_rr_arb (eligible vector, pointer in, one-hot grant out); the FIFOs SHALL be inline arrays.

Verification
REQ-034 SHALL verify single op: requester 2 sends 0x00010000 in cycle 0 -> rsp_valid[2] in cycle 43 carrying the model pipeline output; busy stays high from cycle 1 through the pop.
REQ-035 SHALL verify fairness: all four requesters hold req_valid, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, with no requester skipped.
REQ-036 SHALL verify credit stall: requester 1 holds rsp_ready=0 -> exactly 4 accepts, then req_ready[1]=0; one pop -> one further accept granted the next cycle.
REQ-037 SHALL verify ordering: requester 3 issues 8 distinct operands with random rsp_ready -> all 8 results delivered in order, none lost or duplicated.
REQ-038 SHALL verify mid-flight reset: 10 operations in flight, rst_n pulsed low -> all rsp_valid=0, busy=0; no stale result appears within the next 50 cycles.
